// File: rtl/apb_uart_tx.sv
// APB-attached UART transmitter: byte FIFO feeding an 8N1 serialiser with a programmable baud divisor.
// Optional even-parity bit between data and stop is enabled by defining UART_TX_PARITY_EN.
module apb_uart_tx #(
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [15:0] BAUD_DIV_RST = 16'd868
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [4:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        tx,
    output logic        tx_busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

`ifdef UART_TX_PARITY_EN
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`endif

    logic [7:0]       fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [15:0]      baud_div_r;
    state_t           state_r;
    logic [15:0]      bit_cnt_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r;
    logic             tx_r;

    logic        access_s;
    logic        full_s;
    logic        empty_s;
    logic        stall_s;
    logic        push_s;
    logic        pop_s;
    logic        baud_wr_s;
    logic        pready_s;
    logic [31:0] prdata_s;
    logic [31:0] status_s;
    logic [6:0]  count7_s;
    logic        parity_flag_s;
    logic [15:0] reload_s;
    logic [2:0]  next_idx_s;
    logic        unused_s;

    assign access_s  = PSEL & PENABLE;
    assign full_s    = (count_r == CNT_W'(FIFO_DEPTH));
    assign empty_s   = (count_r == {CNT_W{1'b0}});
    // Full is judged on the registered count, so a same-cycle pop does not release a stalled write.
    assign stall_s   = access_s & PWRITE & (PADDR == 5'd0) & full_s;
    assign push_s    = access_s & PWRITE & (PADDR == 5'd0) & ~full_s;
    assign pop_s     = (state_r == ST_IDLE) & ~empty_s;
    assign baud_wr_s = access_s & PWRITE & (PADDR == 5'd2);
    assign reload_s  = (baud_div_r == 16'd0) ? 16'd0 : (baud_div_r - 16'd1);
    assign next_idx_s = bit_idx_r + 3'd1;
    assign count7_s  = 7'(count_r);
    assign unused_s  = ^PWDATA[31:16];

`ifdef UART_TX_PARITY_EN
    assign parity_flag_s = 1'b1;
`else
    assign parity_flag_s = 1'b0;
`endif

    assign status_s = {21'd0, parity_flag_s, count7_s, (state_r != ST_IDLE), empty_s, full_s};

    // Access-phase ready: wait states only for a TXDATA write into a full FIFO.
    always_comb begin
        pready_s = 1'b0;
        if (access_s) begin
            pready_s = ~stall_s;
        end else begin
            pready_s = 1'b0;
        end
    end

    // Read data mux, driven only during a read access phase.
    always_comb begin
        prdata_s = 32'd0;
        if (access_s && !PWRITE) begin
            case (PADDR)
                5'd1:    prdata_s = status_s;
                5'd2:    prdata_s = {16'd0, baud_div_r};
                default: prdata_s = 32'd0;
            endcase
        end else begin
            prdata_s = 32'd0;
        end
    end

    assign PREADY  = pready_s;
    assign PRDATA  = prdata_s;
    assign tx      = tx_r;
    assign tx_busy = (state_r != ST_IDLE) | ~empty_s;

    // Baud divisor register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            baud_div_r <= BAUD_DIV_RST;
        end else if (baud_wr_s) begin
            baud_div_r <= PWDATA[15:0];
        end
    end

    // FIFO storage; contents are don't-care once the pointers are reset.
    always_ff @(posedge PCLK) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= PWDATA[7:0];
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Transmit FSM; the divisor is sampled at each bit boundary so mid-frame changes apply to the next bit.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_r   <= ST_IDLE;
            tx_r      <= 1'b1;
            bit_cnt_r <= 16'd0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    tx_r <= 1'b1;
                    if (!empty_s) begin
                        shift_r   <= fifo_mem_r[rd_ptr_r];
                        tx_r      <= 1'b0;
                        bit_cnt_r <= reload_s;
                        state_r   <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_cnt_r == 16'd0) begin
                        bit_cnt_r <= reload_s;
                        bit_idx_r <= 3'd0;
                        tx_r      <= shift_r[0];
                        state_r   <= ST_DATA;
                    end else begin
                        bit_cnt_r <= bit_cnt_r - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_cnt_r == 16'd0) begin
                        bit_cnt_r <= reload_s;
                        if (bit_idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx_r    <= even_parity(shift_r);
                            state_r <= ST_PARITY;
`else
                            tx_r    <= 1'b1;
                            state_r <= ST_STOP;
`endif
                        end else begin
                            bit_idx_r <= next_idx_s;
                            tx_r      <= shift_r[next_idx_s];
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r - 16'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_cnt_r == 16'd0) begin
                        bit_cnt_r <= reload_s;
                        tx_r      <= 1'b1;
                        state_r   <= ST_STOP;
                    end else begin
                        bit_cnt_r <= bit_cnt_r - 16'd1;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_cnt_r == 16'd0) begin
                        tx_r    <= 1'b1;
                        state_r <= ST_IDLE;
                    end else begin
                        bit_cnt_r <= bit_cnt_r - 16'd1;
                    end
                end
                default: begin
                    tx_r    <= 1'b1;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
